// File: rtl/scff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scff_pkg
// Purpose  : Shared FSM state encoding and widths for the scan-chain checker.
// Revision : 1.0 - initial release
// ============================================================================
package scff_pkg;

    localparam int              SCFF_CNT_W       = 16;
    localparam int              SCFF_ERR_W       = 8;
    localparam logic [15:0]     SCFF_TIMEOUT_LEN = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        INJECT = 3'd2,
        SHIFT  = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } scff_state_e;

endpackage : scff_pkg
`default_nettype wire

// File: rtl/scff_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : scff_sat_counter
// Purpose  : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module scff_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule : scff_sat_counter
`default_nettype wire

// File: rtl/scff_pulse_checker.sv
`default_nettype none
// ============================================================================
// Module   : scff_pulse_checker
// Purpose  : Flushes a scan chain, injects a single 1 and measures its latency,
//            then checks the tail stays low for POST_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module scff_pulse_checker
    import scff_pkg::*;
#(
    parameter int CHAIN_LEN   = 1024,
    parameter int POST_CYCLES = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start,
    input  logic                  sc_tail,
    output logic                  sc_head,
    output logic                  test_en,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [SCFF_CNT_W-1:0] measured_len,
    output logic [SCFF_ERR_W-1:0] err_count
);

    localparam logic [SCFF_CNT_W-1:0] c_chain_len    = SCFF_CNT_W'(CHAIN_LEN);
    localparam logic [SCFF_CNT_W-1:0] c_flush_last   = SCFF_CNT_W'(CHAIN_LEN - 1);
    localparam logic [SCFF_CNT_W-1:0] c_timeout_last = SCFF_CNT_W'(2 * CHAIN_LEN - 1);
    localparam logic [SCFF_CNT_W-1:0] c_check_last   = SCFF_CNT_W'(POST_CYCLES - 1);

    scff_state_e             r_state;
    scff_state_e             w_state_nxt;
    logic [SCFF_CNT_W-1:0]   w_cnt;
    logic [SCFF_ERR_W-1:0]   w_err;
    logic                    w_cnt_clr;
    logic                    w_cnt_inc;
    logic                    w_err_clr;
    logic                    w_err_inc;
    logic                    w_tail_bad;
    logic                    w_busy_nxt;
    logic                    w_pass_nxt;
    logic [SCFF_CNT_W-1:0]   w_meas_nxt;

    logic                    r_sc_head;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [SCFF_CNT_W-1:0]   r_meas;

    // Anything other than a clean 0 (including X) counts as a violation.
    assign w_tail_bad = (sc_tail !== 1'b0);

    scff_sat_counter #(.WIDTH(SCFF_CNT_W)) u_cycle_cnt (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (w_cnt)
    );

    scff_sat_counter #(.WIDTH(SCFF_ERR_W)) u_err_cnt (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_clr   (w_err_clr),
        .i_inc   (w_err_inc),
        .o_count (w_err)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_err_clr   = 1'b0;
        w_err_inc   = 1'b0;
        w_meas_nxt  = r_meas;
        w_pass_nxt  = r_pass;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = FLUSH;
                    w_cnt_clr   = 1'b1;
                    w_err_clr   = 1'b1;
                    w_meas_nxt  = '0;
                    w_pass_nxt  = 1'b0;
                end
            end
            FLUSH: begin
                if (w_cnt == c_flush_last) begin
                    w_state_nxt = INJECT;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            INJECT: begin
                w_state_nxt = SHIFT;
                w_cnt_clr   = 1'b1;
            end
            SHIFT: begin
                // Counter is one behind the flop count on the arrival cycle.
                if (sc_tail == 1'b1) begin
                    w_state_nxt = CHECK;
                    w_meas_nxt  = w_cnt + SCFF_CNT_W'(1);
                    w_cnt_clr   = 1'b1;
                end else if (w_cnt == c_timeout_last) begin
                    w_state_nxt = DONE;
                    w_meas_nxt  = SCFF_TIMEOUT_LEN;
                    w_pass_nxt  = 1'b0;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            CHECK: begin
                w_err_inc = w_tail_bad;
                if (w_cnt == c_check_last) begin
                    w_state_nxt = DONE;
                    w_cnt_clr   = 1'b1;
                    w_pass_nxt  = (r_meas == c_chain_len) && (w_err == '0) && !w_tail_bad;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == FLUSH) || (w_state_nxt == INJECT) ||
                        (w_state_nxt == SHIFT) || (w_state_nxt == CHECK);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sc_head <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_meas    <= '0;
        end else begin
            r_sc_head <= (w_state_nxt == INJECT);
            r_busy    <= w_busy_nxt;
            r_done    <= (w_state_nxt == DONE);
            r_pass    <= w_pass_nxt;
            r_meas    <= w_meas_nxt;
        end
    end

    assign sc_head      = r_sc_head;
    assign test_en      = r_busy;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign measured_len = r_meas;
    assign err_count    = w_err;

endmodule : scff_pulse_checker
`default_nettype wire
